uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Asynchronous serial receiver, 8N1 framing, LSB first. Inbound side of the
//  logger's host serial link, pairing with the shift-out transmit path.
//  Oversamples the line with a bit-period counter and deserialises into a shift register.
//  Presents each received word on a valid/ack holding register for the command decoder.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per serial bit (50 MHz / 115200); must be >= 4
//  WIDTH         8    data bits per frame
// PORTS
//  clk          in   1      system clock, all state on posedge
//  clr_n        in   1      asynchronous active-low reset
//  rx           in   1      serial line, idle high, asynchronous to clk
//  data         out  WIDTH  last good received word, held while valid
//  valid        out  1      data holds an unconsumed word
//  ack          in   1      consumer takes data; clears valid next cycle
//  frame_err    out  1      1-cycle pulse: stop bit sampled low
//  overrun      out  1      1-cycle pulse: new word delivered while valid=1 and ack=0
// BEHAVIOUR
//  Reset (clr_n=0, async): state=IDLE, counters 0, shift reg 0, data=0,
//   valid=0, frame_err=0, overrun=0, both sync flops=1 (line idle).
//  rx passes through 2-flop synchroniser. rxs is the synced value; 2-cycle latency.
//  Bit counter cnt: 0..CLKS_PER_BIT-1. Bit index idx: 0..WIDTH-1.
//  FSM:
//   IDLE  : rxs=0 -> START, cnt=0.
//   START : at cnt=CLKS_PER_BIT/2-1 sample rxs (mid start bit).
//           rxs=0 -> DATA, cnt=0, idx=0. rxs=1 -> IDLE (glitch, no flag).
//   DATA  : at cnt=CLKS_PER_BIT-1 sample rxs into sreg[idx]; cnt=0.
//           idx=WIDTH-1 -> STOP, else idx++.
//   STOP  : at cnt=CLKS_PER_BIT-1 sample rxs.
//           rxs=1 -> deliver, IDLE. rxs=0 -> frame_err pulse, no deliver, BREAK.
//   BREAK : wait for rxs=1 -> IDLE. A held-low line never re-triggers START.
//  Deliver (registered, 1 cycle after stop sample): data<=sreg, valid<=1.
//   valid=1 and ack=0 at deliver: data overwritten by new word, overrun pulses.
//   ack=1 same cycle as deliver: new word wins, valid stays 1, no overrun.
//   ack while valid=0: ignored.
//  Latency: valid rises 3 + CLKS_PER_BIT/2 + (WIDTH+1)*CLKS_PER_BIT cycles after
//   the first posedge sampling rx=0. That is 155 cycles at CLKS_PER_BIT=16, WIDTH=8.
//  Back-to-back frames: START may be entered the cycle after leaving STOP.
//  Mid-frame clr_n: frame abandoned immediately. After release, rxs starts high;
//   a line still low re-enters START after the 2-cycle sync delay.
//  cnt width = $clog2(CLKS_PER_BIT). All outputs registered.
// TESTING (CLKS_PER_BIT=16, WIDTH=8)
//  1. Send 0xA5, ack held 0 -> data=8'hA5, valid rises at cycle 155, stays until ack.
//  2. Send 0x3C then 0xC3 back-to-back, no ack -> overrun pulse; data=8'hC3; valid=1.
//  3. Send 0x00 with stop bit forced 0 -> frame_err 1 cycle, valid=0, no exit from
//     BREAK until rx=1. Then 0x81 -> data=8'h81.
//  4. rx low pulse of 6 cycles on idle line -> back to IDLE, valid=0, no error pulses.
//  5. Assert clr_n=0 mid DATA of 0xFF frame -> all outputs 0 async. Next 0x5A -> data=8'h5A.
//  6. Ack asserted on deliver cycle of 2nd frame (0x11, 0x22) -> data=8'h22, valid=1, overrun=0.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first: synchronises rx, samples each bit at its
// centre and presents the received word on a valid/ack holding register.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | line idle, waiting for a falling edge on the synced line
//  START | counting to mid start bit to confirm it is not a glitch
//  DATA  | sampling WIDTH data bits, one per bit period, LSB first
//  STOP  | sampling the stop bit; high delivers, low flags frame_err
//  BREAK | stop bit was low, waiting for the line to return high
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int WIDTH        = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             rx,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ack,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] sreg;
  logic             dlv;
  logic             sync_1;
  logic             rxs;

  // Both flops reset high so a released reset looks like an idle line.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_1 <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      sync_1 <= rx;
      rxs    <= sync_1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      sreg      <= '0;
      dlv       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      dlv       <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rxs) state <= S_START;
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            sreg[idx] <= rxs;
            if (idx == IDX_LAST) state <= S_STOP;
            else                 idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rxs) begin
              dlv   <= 1'b1;
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Only a return to idle re-arms; a held-low line must not start a frame.
        S_BREAK: begin
          cnt <= '0;
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A fresh word always wins over a pending ack on the same cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (dlv) begin
        data    <= sreg;
        valid   <= 1'b1;
        overrun <= valid & ~ack;
      end else if (ack) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected words, a negedge
// monitor pops and compares whenever the receiver presents a new word.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int W   = 8;

  logic         clk   = 1'b0;
  logic         clr_n = 1'b0;
  logic         rx    = 1'b1;
  logic         ack   = 1'b0;
  logic [W-1:0] data;
  logic         valid;
  logic         frame_err;
  logic         overrun;

  uart_rx #(.CLKS_PER_BIT(CPB), .WIDTH(W)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ack       (ack),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         ov;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         e;
  int           n_checks = 0;
  int           n_err    = 0;
  int           cyc      = 0;
  int           sof_cyc  = 0;
  int           rise_cyc = 0;
  int           fe_cnt   = 0;
  int           ov_cnt   = 0;
  int           t1;
  int           fe0;
  logic         valid_q  = 1'b0;
  logic [W-1:0] data_q   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a new word is a rise of valid, a data change while valid, or an overrun.
  always @(negedge clk) begin
    if (valid === 1'b1 && (!valid_q || data !== data_q || overrun === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_delivery: got data=%0h expected no word", data);
      end else begin
        e = exp_q.pop_front();
        check("deliver_data", 32'(data), 32'(e.d));
        check("deliver_overrun", 32'(overrun), 32'(e.ov));
      end
      if (!valid_q) rise_cyc = cyc;
    end
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1)   ov_cnt++;
    valid_q = valid;
    data_q  = data;
  end

  // Called at a negedge; each bit is held for CPB cycles.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr      = {stop_bit, b, 1'b0};
    sof_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic ov);
    exp_t x;
    x.d  = d;
    x.ov = ov;
    exp_q.push_back(x);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_data", 32'(data), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    clr_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single word, latency, hold until ack
    push(8'hA5, 1'b0);
    send_byte(8'hA5, 1'b1);
    t1 = sof_cyc;
    check("latency", 32'(rise_cyc - t1 - 1), 32'd155);
    repeat (20) @(negedge clk);
    check("t1_valid_held", 32'(valid), 32'h1);
    check("t1_data_held", 32'(data), 32'hA5);
    ack_pulse();
    check("t1_valid_after_ack", 32'(valid), 32'h0);

    // 2: back-to-back, no ack -> overrun
    push(8'h3C, 1'b0);
    push(8'hC3, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    repeat (4) @(negedge clk);
    check("t2_valid", 32'(valid), 32'h1);
    check("t2_data", 32'(data), 32'hC3);
    ack_pulse();
    check("t2_valid_after_ack", 32'(valid), 32'h0);

    // 3: bad stop bit, line held low, then recovery
    fe0 = fe_cnt;
    send_byte(8'h00, 1'b0);
    repeat (200) @(negedge clk);
    check("t3_frame_err_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("t3_valid", 32'(valid), 32'h0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    push(8'h81, 1'b0);
    send_byte(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    check("t3_data", 32'(data), 32'h81);
    check("t3_valid_after", 32'(valid), 32'h1);
    ack_pulse();

    // 4: short low glitch on an idle line
    fe0 = fe_cnt;
    rx  = 1'b0;
    repeat (6) @(negedge clk);
    rx  = 1'b1;
    repeat (40) @(negedge clk);
    check("t4_valid", 32'(valid), 32'h0);
    check("t4_frame_err_pulses", 32'(fe_cnt - fe0), 32'd0);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: async reset in the middle of a frame
    push(8'h66, 1'b0);
    send_byte(8'h66, 1'b1);
    repeat (4) @(negedge clk);
    check("t5_pre_valid", 32'(valid), 32'h1);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (60) @(negedge clk);
        #2 clr_n = 1'b0;
        #1;
        check("t5_rst_data", 32'(data), 32'h0);
        check("t5_rst_valid", 32'(valid), 32'h0);
        check("t5_rst_frame_err", 32'(frame_err), 32'h0);
        check("t5_rst_overrun", 32'(overrun), 32'h0);
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    check("t5_no_stray_word", 32'(valid), 32'h0);
    push(8'h5A, 1'b0);
    send_byte(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    check("t5_data", 32'(data), 32'h5A);
    ack_pulse();

    // 6: ack coincides with delivery of the second word
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    fork
      begin
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
      end
      begin
        repeat (315) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("t6_valid", 32'(valid), 32'h1);
    check("t6_data", 32'(data), 32'h22);
    ack_pulse();
    check("t6_valid_after_ack", 32'(valid), 32'h0);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("overrun_pulses_total", 32'(ov_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
